// File: rtl/sin_nco_ctrl_pkg.sv
// Shared definitions for the sine NCO control stage and the mixer top.
//   - nco_state_e : FSM state encoding (IDLE=0, LOAD=1, RUN=2)
//   - ram_depth() : table depth helper, 2**exp
//   - RamExpDflt / RamDepthDflt : default table geometry
// Optional feature macro used by this block: SIN_NCO_PHASE_OFS_EN.
package sin_nco_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } nco_state_e;

    localparam int unsigned RamExpDflt   = 5;
    localparam int unsigned RamDepthDflt = 2 ** RamExpDflt;

    function automatic int unsigned ram_depth(input int unsigned exp);
        return 32'd1 << exp;
    endfunction

endpackage

// File: rtl/sin_nco_acc.sv
// Phase accumulator with table-address truncation and optional phase offset.
// Ports:
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   clr_i          : clear accumulator (table load start)
//   step_i         : advance one step and register a new read address
//   fcw_i          : phase step per cycle, unsigned
//   phase_ofs_i    : address offset, present only with SIN_NCO_PHASE_OFS_EN
//   addr_o         : registered read address (acc top bits [+ offset]) mod depth
module sin_nco_acc #(
    parameter int unsigned RAM_EXP   = 5,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 step_i,
    input  logic [ACC_WIDTH-1:0] fcw_i,
`ifdef SIN_NCO_PHASE_OFS_EN
    input  logic [RAM_EXP-1:0]   phase_ofs_i,
`endif
    output logic [RAM_EXP-1:0]   addr_o
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [RAM_EXP-1:0]   addr_q;
    logic [RAM_EXP-1:0]   addr_d;

`ifdef SIN_NCO_PHASE_OFS_EN
    logic [RAM_EXP-1:0]   ofs_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ofs_q <= '0;
        end else begin
            ofs_q <= phase_ofs_i;
        end
    end

    // Sum is RAM_EXP wide, so wrap-around is plain truncation.
    always_comb begin
        addr_d = acc_q[ACC_WIDTH-1 -: RAM_EXP] + ofs_q;
    end
`else
    always_comb begin
        addr_d = acc_q[ACC_WIDTH-1 -: RAM_EXP];
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            addr_q <= '0;
        end else begin
            if (clr_i) begin
                acc_q <= '0;
            end else if (step_i) begin
                acc_q <= acc_q + fcw_i;
            end
            if (step_i) begin
                addr_q <= addr_d;
            end
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/sin_nco_ctrl.sv
// Sine-table control: loads the table RAM from a valid/ready stream, then runs a
// phase accumulator issuing one read address per cycle, with a sample-valid
// strobe aligned to the RAM's 2-cycle registered read.
// Ports:
//   clk, i_rst_n                      : clock, synchronous active-low reset
//   i_load_start, i_load_valid/data   : table load request and sample stream
//   o_load_ready, o_load_done         : load handshake and completion pulse
//   i_enb, i_fcw                      : run request, frequency control word
//   i_phase_ofs                       : address offset (SIN_NCO_PHASE_OFS_EN only)
//   o_addr_w, o_data_ram, o_write_enb : RAM write port
//   o_addr_r, o_read_enb              : RAM read port
//   o_sample_valid, o_table_ok        : RAM output valid, table loaded flag
// Optional feature macro: SIN_NCO_PHASE_OFS_EN.
module sin_nco_ctrl
    import sin_nco_ctrl_pkg::*;
#(
    parameter int unsigned RAM_EXP   = 5,
    parameter int unsigned RAM_WIDTH = 8,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_load_start,
    input  logic                 i_load_valid,
    input  logic [RAM_WIDTH-1:0] i_load_data,
    output logic                 o_load_ready,
    output logic                 o_load_done,
    input  logic                 i_enb,
    input  logic [ACC_WIDTH-1:0] i_fcw,
`ifdef SIN_NCO_PHASE_OFS_EN
    input  logic [RAM_EXP-1:0]   i_phase_ofs,
`endif
    output logic [RAM_EXP-1:0]   o_addr_w,
    output logic [RAM_WIDTH-1:0] o_data_ram,
    output logic                 o_write_enb,
    output logic [RAM_EXP-1:0]   o_addr_r,
    output logic                 o_read_enb,
    output logic                 o_sample_valid,
    output logic                 o_table_ok
);

    localparam int unsigned      RamDepth = ram_depth(RAM_EXP);
    localparam logic [RAM_EXP-1:0] PtrLast = RAM_EXP'(RamDepth - 1);

    nco_state_e state_q, state_d;

    logic [RAM_EXP-1:0]   ptr_q, ptr_d;
    logic                 load_ready_q, load_ready_d;
    logic                 load_done_q, load_done_d;
    logic                 write_enb_q, write_enb_d;
    logic [RAM_EXP-1:0]   addr_w_q, addr_w_d;
    logic [RAM_WIDTH-1:0] data_ram_q, data_ram_d;
    logic                 read_enb_q, read_enb_d;
    logic                 rd_pipe_q;
    logic                 sample_valid_q;
    logic                 table_ok_q, table_ok_d;

    logic load_fire;
    logic load_last;
    logic acc_clr;
    logic run_step;

    // Handshake uses the registered ready, so nothing is accepted in the first
    // LOAD cycle; the state check blocks writes outside LOAD.
    assign load_fire = (state_q == StLoad) && i_load_valid && load_ready_q;
    assign load_last = load_fire && (ptr_q == PtrLast);
    assign acc_clr   = (state_q == StIdle) && i_load_start;
    assign run_step  = (state_q == StRun) && i_enb;

    // State register
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_load_start) begin
                    state_d = StLoad;
                end else if (i_enb && table_ok_q) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                if (load_last) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (!i_enb) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        ptr_d        = ptr_q;
        addr_w_d     = addr_w_q;
        data_ram_d   = data_ram_q;
        write_enb_d  = load_fire;
        load_done_d  = load_last;
        table_ok_d   = table_ok_q | load_last;
        read_enb_d   = run_step;
        // Ready lags entry by one cycle and drops together with the final write.
        load_ready_d = (state_q == StLoad) && (state_d == StLoad);

        if (acc_clr) begin
            ptr_d = '0;
        end else if (load_fire) begin
            ptr_d = ptr_q + RAM_EXP'(1);
        end

        if (load_fire) begin
            addr_w_d   = ptr_q;
            data_ram_d = i_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            ptr_q          <= '0;
            load_ready_q   <= 1'b0;
            load_done_q    <= 1'b0;
            write_enb_q    <= 1'b0;
            addr_w_q       <= '0;
            data_ram_q     <= '0;
            read_enb_q     <= 1'b0;
            rd_pipe_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            table_ok_q     <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            load_ready_q   <= load_ready_d;
            load_done_q    <= load_done_d;
            write_enb_q    <= write_enb_d;
            addr_w_q       <= addr_w_d;
            data_ram_q     <= data_ram_d;
            read_enb_q     <= read_enb_d;
            // Two stages matching the RAM read latency; drains after RUN exits.
            rd_pipe_q      <= read_enb_q;
            sample_valid_q <= rd_pipe_q;
            table_ok_q     <= table_ok_d;
        end
    end

    sin_nco_acc #(
        .RAM_EXP   (RAM_EXP),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .clk_i       (clk),
        .rst_ni      (i_rst_n),
        .clr_i       (acc_clr),
        .step_i      (run_step),
        .fcw_i       (i_fcw),
`ifdef SIN_NCO_PHASE_OFS_EN
        .phase_ofs_i (i_phase_ofs),
`endif
        .addr_o      (o_addr_r)
    );

    assign o_load_ready   = load_ready_q;
    assign o_load_done    = load_done_q;
    assign o_write_enb    = write_enb_q;
    assign o_addr_w       = addr_w_q;
    assign o_data_ram     = data_ram_q;
    assign o_read_enb     = read_enb_q;
    assign o_sample_valid = sample_valid_q;
    assign o_table_ok     = table_ok_q;

endmodule

// File: tb/tb_sin_nco_ctrl.sv
module tb_sin_nco_ctrl;

    logic        clk;
    logic        i_rst_n;
    logic        i_load_start;
    logic        i_load_valid;
    logic [7:0]  i_load_data;
    logic        o_load_ready;
    logic        o_load_done;
    logic        i_enb;
    logic [15:0] i_fcw;
    logic [4:0]  i_phase_ofs;
    logic [4:0]  o_addr_w;
    logic [7:0]  o_data_ram;
    logic        o_write_enb;
    logic [4:0]  o_addr_r;
    logic        o_read_enb;
    logic        o_sample_valid;
    logic        o_table_ok;

    int n_tests;
    int n_fail;
    int done_cnt;
    bit mon_en;

    logic [12:0] wq[$];
    logic [4:0]  rq[$];
    logic [1:0]  hist;
    logic [15:0] m_acc;
    logic [4:0]  ofs_v;

    sin_nco_ctrl u_dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_load_start   (i_load_start),
        .i_load_valid   (i_load_valid),
        .i_load_data    (i_load_data),
        .o_load_ready   (o_load_ready),
        .o_load_done    (o_load_done),
        .i_enb          (i_enb),
        .i_fcw          (i_fcw),
`ifdef SIN_NCO_PHASE_OFS_EN
        .i_phase_ofs    (i_phase_ofs),
`endif
        .o_addr_w       (o_addr_w),
        .o_data_ram     (o_data_ram),
        .o_write_enb    (o_write_enb),
        .o_addr_r       (o_addr_r),
        .o_read_enb     (o_read_enb),
        .o_sample_valid (o_sample_valid),
        .o_table_ok     (o_table_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [12:0] ew;
        logic [4:0]  er;
        if (mon_en) begin
            if (o_write_enb) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 32'(o_addr_w), 32'hFFFF);
                end else begin
                    ew = wq.pop_front();
                    chk("wr_addr", 32'(o_addr_w), 32'(ew[12:8]));
                    chk("wr_data", 32'(o_data_ram), 32'(ew[7:0]));
                end
            end
            if (o_read_enb) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 32'(o_addr_r), 32'hFFFF);
                end else begin
                    er = rq.pop_front();
                    chk("rd_addr", 32'(o_addr_r), 32'(er));
                end
            end
            chk("sample_valid", 32'(o_sample_valid), 32'(hist[1]));
            hist = {hist[0], o_read_enb};
            if (o_load_done) begin
                done_cnt++;
                chk("done_with_last", 32'({o_write_enb, o_addr_w}), 32'h3F);
            end
        end
    end

    // Load the table with sample i = i, valid every other cycle; optional
    // reset in place of write number abort_at.
    task automatic load_table(input int abort_at);
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        i_enb        = 1'b0;
        m_acc        = '0;
        chk("ready_lag", 32'(o_load_ready), 0);
        for (int i = 0; i < 32; i++) begin
            i_load_valid = 1'b1;
            i_load_data  = 8'(i);
            if (i == abort_at) begin
                i_rst_n = 1'b0;
                tick();
                i_rst_n      = 1'b1;
                i_load_valid = 1'b0;
                return;
            end
            for (int w = 0; w < 8 && !o_load_ready; w++) tick();
            if (!o_load_ready) begin
                chk("ready_timeout", 32'(o_load_ready), 1);
                i_load_valid = 1'b0;
                return;
            end
            wq.push_back({5'(i), 8'(i)});
            tick();
            i_load_valid = 1'b0;
            tick();
        end
    endtask

    task automatic run_enter();
        i_enb = 1'b1;
        tick();
    endtask

    task automatic step(input logic [15:0] fcw);
        logic [4:0] a;
        i_fcw = fcw;
        a = m_acc[15:11] + ofs_v;
        rq.push_back(a);
        m_acc = m_acc + fcw;
        tick();
    endtask

    task automatic run_exit();
        i_enb = 1'b0;
        tick();
        chk("rd_off_after_exit", 32'(o_read_enb), 0);
        tick();
        tick();
        tick();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        done_cnt     = 0;
        mon_en       = 1'b0;
        hist         = '0;
        m_acc        = '0;
`ifdef SIN_NCO_PHASE_OFS_EN
        ofs_v        = 5'd8;
`else
        ofs_v        = 5'd0;
`endif
        i_phase_ofs  = ofs_v;
        i_rst_n      = 1'b0;
        i_load_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_data  = '0;
        i_enb        = 1'b1;
        i_fcw        = '0;

        // Reset held 3 cycles with i_enb high
        tick();
        tick();
        tick();
        chk("rst_load_ready", 32'(o_load_ready), 0);
        chk("rst_load_done", 32'(o_load_done), 0);
        chk("rst_write_enb", 32'(o_write_enb), 0);
        chk("rst_read_enb", 32'(o_read_enb), 0);
        chk("rst_sample_valid", 32'(o_sample_valid), 0);
        chk("rst_table_ok", 32'(o_table_ok), 0);
        chk("rst_addr_r", 32'(o_addr_r), 0);
        chk("rst_addr_w", 32'(o_addr_w), 0);
        chk("rst_data_ram", 32'(o_data_ram), 0);
        mon_en  = 1'b1;
        i_rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("enb_no_table", 32'(o_read_enb), 0);
        i_enb = 1'b0;
        tick();

        // Full load
        load_table(-1);
        tick();
        chk("load1_table_ok", 32'(o_table_ok), 1);
        chk("load1_done_cnt", 32'(done_cnt), 1);
        chk("load1_ready_off", 32'(o_load_ready), 0);
        chk("load1_wq_empty", 32'(wq.size()), 0);

        // Run at one address per step: 0..31, 0
        run_enter();
        for (int i = 0; i < 33; i++) step(16'h0800);
        run_exit();
        chk("run1_rq_empty", 32'(rq.size()), 0);

        // Start and enable together: load wins
        i_enb = 1'b1;
        load_table(-1);
        chk("prio_no_read", 32'(o_read_enb), 0);
        tick();
        chk("load2_done_cnt", 32'(done_cnt), 2);
        chk("load2_wq_empty", 32'(wq.size()), 0);

        // Decrementing addresses, fcw change mid-run, load start ignored in RUN
        run_enter();
        for (int i = 0; i < 8; i++) step(16'hF800);
        i_load_start = 1'b1;
        for (int i = 0; i < 6; i++) step(16'h1000);
        i_load_start = 1'b0;
        for (int i = 0; i < 4; i++) step(16'h0000);
        run_exit();
        chk("run2_rq_empty", 32'(rq.size()), 0);
        chk("run2_no_load", 32'(o_load_ready), 0);

        // Resume keeps phase
        run_enter();
        for (int i = 0; i < 5; i++) step(16'h0800);
        run_exit();
        chk("run3_rq_empty", 32'(rq.size()), 0);

        // Reset in place of write 10
        load_table(10);
        chk("abort_table_ok", 32'(o_table_ok), 0);
        chk("abort_wq_empty", 32'(wq.size()), 0);
        i_enb = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_run", 32'(o_read_enb), 0);
        chk("abort_no_valid", 32'(o_sample_valid), 0);
        i_enb = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sin_nco_ctrl.md
# sin_nco_ctrl

Control and addressing stage directly upstream of the sine-table RAM in the mixer path. It loads the table through the RAM write port from a valid/ready stream, then runs a phase accumulator that issues one read address per cycle. It also generates a sample-valid strobe aligned with the RAM's 2-cycle registered read output, for the downstream multiplier.

## Interface
- RAM_EXP, 5, log2 of table depth; RAM_DEPTH = 2**RAM_EXP
- RAM_WIDTH, 8, table sample width
- ACC_WIDTH, 16, phase accumulator width; must be ≥ RAM_EXP

- clk  in  1  clock, all logic on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_load_start  in  1  request table (re)load; honoured only in IDLE
- i_load_valid  in  1  load data valid
- i_load_data  in  RAM_WIDTH  table sample, written in address order 0..RAM_DEPTH-1
- o_load_ready  out  1  high in LOAD
- o_load_done  out  1  one-cycle pulse after final table write
- i_enb  in  1  run request; oscillate while high
- i_fcw  in  ACC_WIDTH  frequency control word (phase step per cycle, unsigned)
- o_addr_w  out  RAM_EXP  RAM write address
- o_data_ram  out  RAM_WIDTH  RAM write data
- o_write_enb  out  1  RAM write enable
- o_addr_r  out  RAM_EXP  RAM read address
- o_read_enb  out  1  RAM read enable
- o_sample_valid  out  1  RAM output holds the sample for a read issued 2 cycles earlier
- o_table_ok  out  1  a complete table has been loaded since reset

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE, accumulator = 0, write pointer = 0, o_table_ok = 0, and all outputs 0.
- IDLE:
  - i_load_start → LOAD; pointer and accumulator cleared.
  - Otherwise, i_enb & o_table_ok → RUN.
  - If i_load_start and i_enb are high together, load wins.
  - i_enb while o_table_ok = 0 is ignored and the block stays in IDLE.
- LOAD:
  - Each cycle with i_load_valid & o_load_ready registers o_write_enb = 1, o_addr_w = pointer, o_data_ram = i_load_data, then increments the pointer.
  - The write at pointer RAM_DEPTH-1 → IDLE, with o_load_done pulsed and o_table_ok set in the same cycle as that last o_write_enb.
  - i_load_start and i_enb are ignored in LOAD. Gaps in i_load_valid stall the load with no timeout.
  - If i_rst_n is asserted mid-load, o_table_ok = 0 and a full reload is required.
- RAM writes are issued only from LOAD; o_write_enb = 0 in every other state.
- RUN:
  - Every cycle: o_read_enb = 1; o_addr_r = acc[ACC_WIDTH-1 -: RAM_EXP] (+ offset, see Configuration), modulo RAM_DEPTH; acc ← acc + i_fcw, wrapping mod 2**ACC_WIDTH.
  - i_fcw is sampled every cycle, so a change takes effect on the next step.
  - i_enb low → IDLE with o_read_enb = 0. The accumulator holds its value, so a re-entry resumes the phase.
  - i_load_start is ignored in RUN.
- i_fcw = 0 gives a constant address. Address wrap-around is natural truncation.

## Timing
- All outputs are registered.
- First RUN cycle: o_addr_r = top bits of the held accumulator (0 after a load).
- o_sample_valid = o_read_enb delayed by 2 registers. It is asserted in cycles n+2 when o_read_enb was high in cycle n.
- The valid pipeline drains after RUN exits, so the last 2 valids still assert.
- o_load_ready changes one cycle after the state change. The first write happens no earlier than the second cycle after i_load_start.

## Configuration
- SIN_NCO_PHASE_OFS_EN:
  - Defined: adds input i_phase_ofs [RAM_EXP-1:0], registered every cycle. o_addr_r = acc top bits + registered offset, mod RAM_DEPTH. This enables quadrature (cos) via offset RAM_DEPTH/4.
  - Undefined: no port and no adder; address = acc top bits.

## Structure
- Shared package: state encoding (IDLE=0, LOAD=1, RUN=2) and a helper constant for RAM_DEPTH = 2**RAM_EXP, shared with the mixer top.
- One natural sub-module, sin_nco_acc: the accumulator with optional offset adder and address truncation. The FSM and load logic stay in the top module.

## Test plan
- Reset: hold i_rst_n=0 for 3 cycles with i_enb=1 → all outputs 0, state IDLE, o_table_ok=0; i_enb causes no reads.
- Load: i_load_start, then 32 samples 0x00..0x1F with valid every other cycle → 32 writes at addresses 0..31 with data equal to the address; o_load_done pulses once; o_table_ok=1.
- Run: ACC_WIDTH=16, i_fcw=0x0800 → o_addr_r = 0,1,2,…,31,0; o_sample_valid rises exactly 2 cycles after o_read_enb.
- Wrap/step: i_fcw=0xF800 → addresses decrement 0,31,30,…; an i_fcw change mid-run takes effect on the next step.
- Priority/ignore: i_load_start and i_enb together in IDLE → LOAD entered. i_load_start during RUN → no writes. i_rst_n low at write 10 → o_table_ok=0 and i_enb yields no RUN.
- SIN_NCO_PHASE_OFS_EN: i_phase_ofs=8, i_fcw=0x0800 → addresses 8,9,…,31,0.
